// File: rtl/icache_nway.sv
// icache_nway: set-associative instruction cache with single-line L2 refill.
// Define ICACHE_PLRU_EN to swap per-set round-robin replacement for tree pseudo-LRU.
module icache_nway #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_BYTES  = 64,
  parameter int WAYS        = 4,
  parameter int SETS        = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    cpu_req_valid_i,
  output logic                    cpu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cpu_req_addr_i,
  output logic                    cpu_resp_valid_o,
  input  logic                    cpu_resp_ready_i,
  output logic [INSTR_WIDTH-1:0]  cpu_resp_instr_o,
  output logic                    l2_req_valid_o,
  input  logic                    l2_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   l2_req_addr_o,
  input  logic                    l2_resp_valid_i,
  input  logic [LINE_BYTES*8-1:0] l2_resp_data_i
);
  localparam int OFFSET = $clog2(LINE_BYTES);
  localparam int INDEX  = $clog2(SETS);
  localparam int TAG    = ADDR_WIDTH - OFFSET - INDEX;
  localparam int LOG    = $clog2(WAYS);
  localparam int WAYB   = LOG > 0 ? LOG : 1;
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOOKUP      = 3'd1;
  localparam logic [2:0] REFILL_REQ  = 3'd2;
  localparam logic [2:0] REFILL_WAIT = 3'd3;
  localparam logic [2:0] RESP        = 3'd4;
  logic [2:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [INSTR_WIDTH-1:0]       instr_q, instr_d;
  logic                         flush_q, flush_d;
  logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
  logic [SETS-1:0][WAYB-1:0]    rr_q, rr_d;
  logic [TAG-1:0]               tag_mem  [SETS][WAYS];
  logic [LINE_BYTES*8-1:0]      data_mem [SETS][WAYS];
  logic [INDEX-1:0]             idx;
  logic [TAG-1:0]               tag;
  logic [OFFSET-3:0]            word;
  logic [WAYS-1:0]              hit_vec;
  logic [WAYB-1:0]              hit_way, free_way, repl_way, victim;
  logic [LINE_BYTES*8-1:0]      hit_line;
  logic                         fill;
  logic                         unused_addr;
  assign idx         = addr_q[OFFSET +: INDEX];
  assign tag         = addr_q[ADDR_WIDTH-1 -: TAG];
  assign word        = addr_q[OFFSET-1:2];
  assign unused_addr = ^addr_q[1:0];
`ifdef ICACHE_PLRU_EN
  logic [SETS-1:0][WAYS-1:0] plru_q, plru_d;
  // Node n of the tree lives in bit n (heap order); a set bit points at the colder right half.
  function automatic logic [WAYB-1:0] plru_victim(input logic [WAYS-1:0] t);
    int n;
    n = 1;
    for (int l = 0; l < LOG; l++) n = 2 * n + int'(t[n]);
    return WAYB'(n - WAYS);
  endfunction
  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t, input logic [WAYB-1:0] w);
    int n;
    n = 1;
    plru_touch = t;
    for (int l = LOG - 1; l >= 0; l--) begin
      plru_touch[n] = ~w[l];
      n = 2 * n + int'(w[l]);
    end
  endfunction
  assign repl_way = plru_victim(plru_q[idx]);
`else
  assign repl_way = rr_q[idx];
`endif
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[idx][w] && tag_mem[idx][w] == tag;
      if (hit_vec[w]) hit_way = WAYB'(w);
      if (!valid_q[idx][w]) free_way = WAYB'(w);
    end
  end
  assign victim   = &valid_q[idx] ? repl_way : free_way;
  assign hit_line = data_mem[idx][hit_way];
  assign fill     = state_q == REFILL_WAIT && l2_resp_valid_i;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    flush_d = flush_q || (flush_i && state_q != IDLE);
    valid_d = valid_q;
    rr_d    = rr_q;
`ifdef ICACHE_PLRU_EN
    plru_d  = plru_q;
`endif
    case (state_q)
      IDLE: begin
        if (flush_i || flush_q) begin
          valid_d = '0;
          flush_d = 1'b0;
        end else if (cpu_req_valid_i) begin
          addr_d  = cpu_req_addr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = |hit_vec ? RESP : REFILL_REQ;
        if (|hit_vec) begin
          instr_d = hit_line[{word, 5'd0} +: INSTR_WIDTH];
`ifdef ICACHE_PLRU_EN
          plru_d[idx] = plru_touch(plru_q[idx], hit_way);
`endif
        end
      end
      REFILL_REQ: state_d = l2_req_ready_i ? REFILL_WAIT : REFILL_REQ;
      REFILL_WAIT: begin
        if (fill) begin
          valid_d[idx][victim] = 1'b1;
          rr_d[idx]            = WAYS == 1 ? '0 : rr_q[idx] + 1'b1;
          instr_d              = l2_resp_data_i[{word, 5'd0} +: INSTR_WIDTH];
          state_d              = RESP;
`ifdef ICACHE_PLRU_EN
          plru_d[idx] = plru_touch(plru_q[idx], victim);
`endif
        end
      end
      RESP: state_d = cpu_resp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      flush_q <= 1'b0;
      valid_q <= '0;
      rr_q    <= '0;
`ifdef ICACHE_PLRU_EN
      plru_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
`ifdef ICACHE_PLRU_EN
      plru_q  <= plru_d;
`endif
    end
  end
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_mem[idx][victim]  <= tag;
      data_mem[idx][victim] <= l2_resp_data_i;
    end
  end
  assign cpu_req_ready_o  = state_q == IDLE && !flush_q && !flush_i && !rst_i;
  assign cpu_resp_valid_o = state_q == RESP;
  assign cpu_resp_instr_o = instr_q;
  assign l2_req_valid_o   = state_q == REFILL_REQ;
  assign l2_req_addr_o    = l2_req_valid_o ? {addr_q[ADDR_WIDTH-1:OFFSET], OFFSET'(0)} : '0;
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: randomized and directed checks of icache_nway against a set/way reference model.
module tb_icache_nway;
  localparam int WAYS = 4;
  localparam int SETS = 64;
  logic         clk = 0, rst_i = 1, flush_i = 0, req_valid = 0, resp_ready = 0;
  logic         l2_ready = 0, l2_valid = 0;
  logic [31:0]  req_addr = 0;
  logic [511:0] l2_data = '0;
  logic         req_ready, resp_valid, l2_req_valid;
  logic [31:0]  resp_instr, l2_addr;
  int           n_chk = 0, n_fail = 0;
  bit           rand_data = 0;
  bit           mv [SETS][WAYS];
  int           mt [SETS][WAYS];
  int           mrr [SETS];
  bit           mpl [SETS][WAYS];

  icache_nway dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .cpu_req_valid_i(req_valid), .cpu_req_ready_o(req_ready), .cpu_req_addr_i(req_addr),
    .cpu_resp_valid_o(resp_valid), .cpu_resp_ready_i(resp_ready), .cpu_resp_instr_o(resp_instr),
    .l2_req_valid_o(l2_req_valid), .l2_req_ready_i(l2_ready), .l2_req_addr_o(l2_addr),
    .l2_resp_valid_i(l2_valid), .l2_resp_data_i(l2_data)
  );

  initial forever #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] l2_word(input logic [31:0] la, input int k);
    return rand_data ? ((la * 32'h9E3779B1) ^ 32'h0F0F0000) + k : 32'hA000_0000 + k;
  endfunction

  function automatic logic [511:0] l2_line(input logic [31:0] la);
    for (int k = 0; k < 16; k++) l2_line[k*32 +: 32] = l2_word(la, k);
  endfunction

  function automatic int m_find(input int s, input int t);
    for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    int lo, hi, node, mid;
    for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
`ifdef ICACHE_PLRU_EN
    lo = 0; hi = WAYS; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mpl[s][node]) begin lo = mid; node = 2 * node + 1; end
      else begin hi = mid; node = 2 * node; end
    end
    return lo;
`else
    lo = 0; hi = 0; node = 0; mid = 0;
    return mrr[s];
`endif
  endfunction

  task automatic m_touch(input int s, input int w);
`ifdef ICACHE_PLRU_EN
    int lo, hi, node, mid;
    bit right;
    lo = 0; hi = WAYS; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      right = w >= mid;
      mpl[s][node] = !right;
      node = 2 * node + int'(right);
      if (right) lo = mid; else hi = mid;
    end
`else
    mt[s][w] = mt[s][w];
`endif
  endtask

  task automatic m_access(input logic [31:0] a);
    int s, t, w;
    s = int'(a[11:6]); t = int'(a[31:12]);
    w = m_find(s, t);
    if (w < 0) begin
      w = m_victim(s);
      mv[s][w] = 1; mt[s][w] = t;
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
    m_touch(s, w);
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; mpl[s][w] = 0; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_i = 1;
    @(negedge clk); rst_i = 0;
    m_reset();
  endtask

  // Drives one fetch and any refill it triggers; returns what was observed.
  task automatic fetch(input logic [31:0] a, input int l2_stall, input int resp_stall, input bit flush_mid,
                       output bit missed, output logic [31:0] l2a, output logic [31:0] instr,
                       output int lat, output bit stable, output bit tmo);
    int n;
    missed = 0; l2a = 0; instr = 0; lat = 0; stable = 1; tmo = 0; n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tmo = req_ready !== 1'b1;
    req_valid = 1; req_addr = a;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 60) begin
      if (l2_req_valid === 1'b1) begin
        missed = 1; l2a = l2_addr;
        for (int i = 0; i < l2_stall; i++) begin
          @(negedge clk); lat++;
          if (l2_req_valid !== 1'b1 || l2_addr !== l2a) stable = 0;
        end
        l2_ready = 1;
        @(negedge clk); lat++;
        l2_ready = 0; l2_valid = 1; l2_data = l2_line(l2a);
        @(negedge clk); lat++;
        l2_valid = 0; l2_data = {16{$urandom}};
      end else begin
        @(negedge clk); lat++;
      end
    end
    if (resp_valid !== 1'b1) tmo = 1;
    instr = resp_instr;
    for (int i = 0; i < resp_stall; i++) begin
      if (flush_mid && i == 1) flush_i = 1;
      @(negedge clk);
      flush_i = 0;
      if (resp_valid !== 1'b1 || resp_instr !== instr) stable = 0;
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({req_ready, resp_valid, l2_req_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {req_ready, resp_valid, l2_req_valid});
    end
    n_chk++;
    if (resp_instr !== 32'h0 || l2_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: instr %h addr %h expected 0 0", resp_instr, l2_addr);
    end
    rst_i = 0;
    m_reset();
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_cold_miss_hit();
    bit m, st, to; logic [31:0] la, ins; int lat;
    fetch(32'h0000_1044, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b01 || la !== 32'h0000_1040) begin
      n_fail++; $display("FAIL cold_miss_req: tmo/miss %b%b addr %h expected 01 00001040", to, m, la);
    end
    n_chk++;
    if (ins !== 32'hA000_0001) begin n_fail++; $display("FAIL cold_miss_data: got %h expected a0000001", ins); end
    fetch(32'h0000_1048, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b00 || lat !== 2) begin
      n_fail++; $display("FAIL hit_latency: tmo/miss %b%b lat %0d expected 00 2", to, m, lat);
    end
    n_chk++;
    if (ins !== 32'hA000_0002) begin n_fail++; $display("FAIL hit_data: got %h expected a0000002", ins); end
  endtask

  task automatic test_flush();
    bit m, st, to; logic [31:0] la, ins; int lat;
    flush_i = 1;
    #1;
    n_chk++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
    @(negedge clk);
    flush_i = 0;
    fetch(32'h0000_1044, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b01 || la !== 32'h0000_1040 || ins !== 32'hA000_0001) begin
      n_fail++; $display("FAIL flush_refetch: tmo/miss %b%b addr %h instr %h expected 01 00001040 a0000001", to, m, la, ins);
    end
    fetch(32'h0000_1048, 0, 3, 1, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m, st} !== 3'b001 || ins !== 32'hA000_0002) begin
      n_fail++; $display("FAIL flush_pending_resp: tmo/miss/stable %b%b%b instr %h expected 001 a0000002", to, m, st, ins);
    end
    fetch(32'h0000_1048, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b01) begin n_fail++; $display("FAIL flush_pending_applied: tmo/miss %b%b expected 01", to, m); end
  endtask

  task automatic test_stall();
    bit m, st, to; logic [31:0] la, ins; int lat;
    fetch(32'h0000_2084, 3, 5, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m, st} !== 3'b011) begin
      n_fail++; $display("FAIL stall_stability: tmo/miss/stable %b%b%b expected 011", to, m, st);
    end
    n_chk++;
    if (la !== 32'h0000_2080 || ins !== 32'hA000_0001) begin
      n_fail++; $display("FAIL stall_data: addr %h instr %h expected 00002080 a0000001", la, ins);
    end
  endtask

  task automatic test_reset_refill();
    bit m, st, to; logic [31:0] la, ins; int lat, n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_addr = 32'h0000_5044;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (l2_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_chk++;
    if (l2_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_refill_req: got %b expected 1", l2_req_valid); end
    l2_ready = 1;
    @(negedge clk);
    l2_ready = 0;
    rst_i = 1;
    #1;
    n_chk++;
    if ({req_ready, resp_valid, l2_req_valid, resp_instr, l2_addr} !== 67'h0) begin
      n_fail++; $display("FAIL rst_refill_outputs: ctrl %b instr %h addr %h expected 000 0 0",
                         {req_ready, resp_valid, l2_req_valid}, resp_instr, l2_addr);
    end
    @(negedge clk);
    l2_valid = 1; l2_data = l2_line(32'h0000_5040);
    @(negedge clk);
    rst_i = 0;
    m_reset();
    @(negedge clk);
    l2_valid = 0;
    n_chk++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_refill_ignore: valid/ready %b expected 01", {resp_valid, req_ready});
    end
    fetch(32'h0000_1044, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b01 || ins !== 32'hA000_0001) begin
      n_fail++; $display("FAIL rst_refill_miss: tmo/miss %b%b instr %h expected 01 a0000001", to, m, ins);
    end
  endtask

  task automatic test_replacement();
    bit m, st, to; logic [31:0] la, ins, keep, gone; int lat, misses;
`ifdef ICACHE_PLRU_EN
    keep = 32'h0000_0000; gone = 32'h0000_2000;
`else
    keep = 32'h0000_2000; gone = 32'h0000_0000;
`endif
    do_reset();
    misses = 0;
    for (int i = 0; i < 4; i++) begin
      fetch(32'h1000 * i, 0, 0, 0, m, la, ins, lat, st, to);
      misses += int'(m);
    end
    n_chk++;
    if (misses !== 4) begin n_fail++; $display("FAIL repl_fill: misses %0d expected 4", misses); end
    fetch(32'h0000_0000, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b00) begin n_fail++; $display("FAIL repl_hit0: tmo/miss %b%b expected 00", to, m); end
    fetch(32'h0000_4000, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b01 || ins !== 32'hA000_0000) begin
      n_fail++; $display("FAIL repl_miss4: tmo/miss %b%b instr %h expected 01 a0000000", to, m, ins);
    end
    fetch(32'h0000_1000, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b00) begin n_fail++; $display("FAIL repl_hit1: tmo/miss %b%b expected 00", to, m); end
    fetch(32'h0000_3000, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b00) begin n_fail++; $display("FAIL repl_hit3: tmo/miss %b%b expected 00", to, m); end
    fetch(keep, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b00) begin n_fail++; $display("FAIL repl_kept: tmo/miss %b%b expected 00", to, m); end
    fetch(gone, 0, 0, 0, m, la, ins, lat, st, to);
    n_chk++;
    if ({to, m} !== 2'b01) begin n_fail++; $display("FAIL repl_evicted: tmo/miss %b%b expected 01", to, m); end
  endtask

  task automatic test_random();
    bit m, st, to, em; logic [31:0] a, la, ins; int lat, s, t, wd;
    do_reset();
    rand_data = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        for (int x = 0; x < SETS; x++) for (int w = 0; w < WAYS; w++) mv[x][w] = 0;
      end
      s = $urandom_range(0, 2); t = $urandom_range(0, 5); wd = $urandom_range(0, 15);
      a = (t << 12) | (s << 6) | (wd << 2) | $urandom_range(0, 3);
      em = m_find(s, t) < 0;
      fetch(a, $urandom_range(0, 2), $urandom_range(0, 2), 0, m, la, ins, lat, st, to);
      n_chk++;
      if ({to, m, st} !== {1'b0, em, 1'b1}) begin
        n_fail++; $display("FAIL rand_miss[%0d] addr %h: tmo/miss/stable %b%b%b expected 0%b1", i, a, to, m, st, em);
      end
      n_chk++;
      if (ins !== l2_word(a & ~32'h3F, wd) || (em && la !== (a & ~32'h3F))) begin
        n_fail++; $display("FAIL rand_data[%0d] addr %h: instr %h l2addr %h expected %h %h",
                           i, a, ins, la, l2_word(a & ~32'h3F, wd), a & ~32'h3F);
      end
      m_access(a);
    end
    rand_data = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_flush();
    test_stall();
    test_reset_refill();
    test_replacement();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction width; fixed at 32.
REQ-003 SHALL have parameter LINE_BYTES, default 64, line size; power of two, >= 8.
REQ-004 SHALL have parameter WAYS, default 4, associativity; power of two, 1..8.
REQ-005 SHALL have parameter SETS, default 64, set count; power of two; OFFSET=log2(LINE_BYTES), INDEX=log2(SETS), TAG=ADDR_WIDTH-OFFSET-INDEX.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset; flush_i in 1 FENCE.I invalidate-all.
REQ-007 SHALL have ports: cpu_req_valid_i in 1; cpu_req_ready_o out 1; cpu_req_addr_i in ADDR_WIDTH fetch address.
REQ-008 SHALL have ports: cpu_resp_valid_o out 1; cpu_resp_ready_i in 1; cpu_resp_instr_o out INSTR_WIDTH instruction.
REQ-009 SHALL have ports: l2_req_valid_o out 1; l2_req_ready_i in 1; l2_req_addr_o out ADDR_WIDTH line-aligned refill address; l2_resp_valid_i in 1; l2_resp_data_i in LINE_BYTES*8 line data, byte 0 in bits [7:0].
REQ-010 SHALL use one clock, clk_i; reset rst_i is asynchronous and active-high.

Function
REQ-011 SHALL implement FSM IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP, with cpu_req_ready_o=1 only in IDLE and no flush pending.
REQ-012 SHALL register address on request accept (cycle 0) and enter LOOKUP; address bits [1:0] ignored.
REQ-013 SHALL in LOOKUP compare the registered tag with all valid ways of the indexed set in parallel; hit -> RESP, cpu_resp_valid_o asserted cycle 2.
REQ-014 SHALL on miss enter REFILL_REQ, drive l2_req_valid_o=1 with l2_req_addr_o = address with offset bits zeroed, both held stable until l2_req_ready_i=1, then REFILL_WAIT.
REQ-015 SHALL in REFILL_WAIT, on l2_resp_valid_i=1, write line, tag and valid=1 into the victim way, update replacement state, go to RESP returning the requested word from l2_resp_data_i.
REQ-016 SHALL select victim = lowest-numbered invalid way; if all valid, per-set round-robin pointer, incremented modulo WAYS on each refill of that set.
REQ-017 SHALL in RESP hold cpu_resp_valid_o=1 and cpu_resp_instr_o stable until cpu_resp_ready_i=1, then return to IDLE; cpu_resp_instr_o is word addr[OFFSET-1:2] of the line.
REQ-018 SHALL ignore l2_resp_valid_i in any state other than REFILL_WAIT.
REQ-019 SHALL on flush_i in IDLE clear all valid bits at the next edge, cpu_req_ready_o=0 that cycle; flush_i in other states latched as pending and applied on return to IDLE, after the in-flight response completes.
REQ-020 SHALL, with WAYS=1, always replace way 0.

Reset
REQ-021 SHALL on rst_i=1 immediately force IDLE, clear all valid bits, replacement state and pending flush, and drive cpu_req_ready_o=0, cpu_resp_valid_o=0, cpu_resp_instr_o=0, l2_req_valid_o=0, l2_req_addr_o=0; cpu_req_ready_o=1 first cycle after release.
REQ-022 SHALL abandon any in-flight refill on reset; tag/data arrays need no reset.

Configuration
REQ-023 SHALL, with ICACHE_PLRU_EN defined, replace round-robin with tree pseudo-LRU per set (WAYS-1 bits, updated on hit and refill, invalid-way priority retained); undefined, round-robin per REQ-016.

Verification
REQ-024 Cold miss 0x0000_1044, L2 word k = 0xA000_0000+k -> l2_req_addr_o=0x0000_1040, resp 0xA000_0001; then 0x0000_1048 -> hit, resp 0xA000_0002 at cycle 2, no l2_req_valid_o.
REQ-025 WAYS=4,SETS=64: miss-fill 0x0000,0x1000,0x2000,0x3000, hit 0x0000, miss 0x4000 -> evicts 0x0000 (round-robin) / 0x2000 (ICACHE_PLRU_EN); next 0x1000 hits.
REQ-026 After REQ-024, flush_i one cycle in IDLE -> 0x0000_1044 misses, L2 request reissued.
REQ-027 cpu_resp_ready_i low 5 cycles and l2_req_ready_i low 3 cycles -> cpu_resp_valid_o/instr and l2_req_valid_o/addr stable throughout.
REQ-028 rst_i asserted in REFILL_WAIT -> outputs zero same cycle; later l2_resp_valid_i ignored; next 0x0000_1044 misses.
